// File: rtl/cordic_pkg.sv
// Shared constants and types for the rotation-mode CORDIC pipeline.
// Angles are unsigned 16-bit turns (65536 = 360 deg); accumulators are Q18.16.
package cordic_pkg;

  localparam int ANGLE_W = 16;
  localparam int ACC_W   = 34;

  // Reciprocal of the CORDIC gain, 1/1.646760 in Q0.16.
  localparam logic [15:0] KINV = 16'd39797;

  localparam int ATAN_TABLE [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                     41, 20, 10, 5, 3, 1, 1, 0};

  typedef enum logic [1:0] {
    QUAD_I   = 2'b00,
    QUAD_II  = 2'b01,
    QUAD_III = 2'b10,
    QUAD_IV  = 2'b11
  } quadrant_t;

  typedef struct packed {
    logic signed [ACC_W-1:0]   x;
    logic signed [ACC_W-1:0]   y;
    logic signed [ANGLE_W:0]   z;
    logic                      valid;
    logic                      last;
    logic [3:0]                strb;
  } stage_t;

endpackage

// File: rtl/cordic_rotate_if.sv
// AXI-Stream beat bundle used on both sides of cordic_rotate.
interface cordic_rotate_if
  import cordic_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [3:0]        tstrb;

  modport master (output tdata, tvalid, tlast, tstrb, input tready);
  modport slave  (input tdata, tvalid, tlast, tstrb, output tready);
endinterface

// File: rtl/cordic_rot_stage.sv
// One registered CORDIC micro-rotation (rotation mode); holds its contents while en is low.
module cordic_rot_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);
  localparam int Z_W = ANGLE_W + 1;
  localparam logic signed [Z_W-1:0] ATAN_STEP = Z_W'(ATAN_TABLE[SHIFT]);

  logic signed [ACC_W-1:0] x_in, y_in, x_sh, y_sh;
  logic signed [Z_W-1:0]   z_in;

  assign x_in = d.x;
  assign y_in = d.y;
  assign z_in = d.z;
  assign x_sh = x_in >>> SHIFT;
  assign y_sh = y_in >>> SHIFT;

  always_ff @(posedge clk) begin
    if (en) begin
      if (!z_in[Z_W-1]) begin
        q.x <= x_in - y_sh;
        q.y <= y_in + x_sh;
        q.z <= z_in - ATAN_STEP;
      end else begin
        q.x <= x_in + y_sh;
        q.y <= y_in - x_sh;
        q.z <= z_in + ATAN_STEP;
      end
      q.last <= d.last;
      q.strb <= d.strb;
    end
    if (rst)
      q.valid <= 1'b0;
    else if (en)
      q.valid <= d.valid;
  end

endmodule

// File: rtl/cordic_rotate.sv
// Polar-to-rectangular CORDIC: {angle, magnitude} in, {Q, I} out, one beat per cycle.
// Define CORDIC_ROT_SAT_EN to clamp outputs to +/-32767 instead of wrapping.
module cordic_rotate
  import cordic_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int NUM_ITERS              = 16
) (
  input  logic            s00_axis_aclk,
  input  logic            s00_axis_areset,
  cordic_rotate_if.slave  s00_axis,
  cordic_rotate_if.master m00_axis
);
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(32768);

  if (NUM_ITERS < 8 || NUM_ITERS > 16) begin : g_bad_iters
    $error("cordic_rotate: NUM_ITERS must lie in 8..16");
  end
  if (C_S00_AXIS_TDATA_WIDTH != 32 || C_M00_AXIS_TDATA_WIDTH != 32) begin : g_bad_width
    $error("cordic_rotate: only 32-bit tdata is supported");
  end

  function automatic logic [15:0] round_sat(input logic signed [ACC_W-1:0] v);
`ifdef CORDIC_ROT_SAT_EN
    logic signed [ACC_W-17:0] t;
    t = (ACC_W-16)'((v + ROUND_HALF) >>> 16);
    if (t > 18'sd32767)
      return 16'h7FFF;
    else if (t < -18'sd32767)
      return 16'h8001;
    else
      return t[15:0];
`else
    return 16'((v + ROUND_HALF) >>> 16);
`endif
  endfunction

  logic                     en;
  logic [ANGLE_W-1:0]       angle;
  logic [15:0]              mag;
  quadrant_t                quad;
  logic                     flip;
  logic [31:0]              prod;
  logic signed [ACC_W-1:0]  x_mag;
  logic signed [ANGLE_W:0]  z_pre;

  stage_t pre_p0;
  stage_t rot_p1 [0:NUM_ITERS];
  stage_t fin_p1;
  logic   unused_z_p1;

  assign en              = !m00_axis.tvalid || m00_axis.tready;
  assign s00_axis.tready = en && !s00_axis_areset;

  assign angle = s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1 -: ANGLE_W];
  assign mag   = s00_axis.tdata[15:0];
  assign quad  = quadrant_t'(angle[ANGLE_W-1 -: 2]);
  assign flip  = (quad == QUAD_II) || (quad == QUAD_III);
  assign prod  = 32'(mag) * 32'(KINV);
  assign x_mag = {{(ACC_W-32){1'b0}}, prod};
  // Quadrants II/III are pre-rotated by 180 deg so the residual stays within +/-90 deg.
  assign z_pre = flip ? $signed({1'b0, angle} - 17'd32768) : $signed({angle[ANGLE_W-1], angle});

  // ---- p0: gain pre-compensation and quadrant fold ----
  always_ff @(posedge s00_axis_aclk) begin
    if (en) begin
      pre_p0.x    <= flip ? -x_mag : x_mag;
      pre_p0.y    <= '0;
      pre_p0.z    <= z_pre;
      pre_p0.last <= s00_axis.tlast;
      pre_p0.strb <= s00_axis.tstrb;
    end
    if (s00_axis_areset)
      pre_p0.valid <= 1'b0;
    else if (en)
      pre_p0.valid <= s00_axis.tvalid;
  end

  // ---- p1: micro-rotation chain ----
  assign rot_p1[0] = pre_p0;

  for (genvar i = 0; i < NUM_ITERS; i++) begin : g_rot
    cordic_rot_stage #(.SHIFT(i)) u_stage (
      .clk (s00_axis_aclk),
      .rst (s00_axis_areset),
      .en  (en),
      .d   (rot_p1[i]),
      .q   (rot_p1[i+1])
    );
  end

  assign fin_p1      = rot_p1[NUM_ITERS];
  assign unused_z_p1 = ^fin_p1.z;

  // ---- p2: round, saturate/wrap, output register ----
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      m00_axis.tvalid <= 1'b0;
      m00_axis.tlast  <= 1'b0;
      m00_axis.tdata  <= '0;
      m00_axis.tstrb  <= 4'hF;
    end else if (en) begin
      m00_axis.tvalid <= fin_p1.valid;
      m00_axis.tlast  <= fin_p1.last;
      m00_axis.tstrb  <= fin_p1.strb;
      m00_axis.tdata  <= {round_sat(fin_p1.y), round_sat(fin_p1.x)};
    end
  end

endmodule
